// File: rtl/dm_pkg.sv
// Shared encodings for the data memory: access sizes and controller states.
package dm_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane handling: store merge, load extract/extend and fault decode.
// Zero latency; no flow control of its own.
module dm_lane_align
   import dm_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   input  logic        sign_ext,
   input  logic        oob,
   output logic [31:0] merged,
   output logic [31:0] load_data,
   output logic        fault
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign byte_v = old_word[{lane, 3'b000} +: 8];
   assign half_v = old_word[{lane[1], 4'b0000} +: 16];

   always_comb begin
      merged    = old_word;
      load_data = old_word;
      fault     = oob;
      case (size_e'(size))
         SZ_BYTE: begin
            merged[{lane, 3'b000} +: 8] = wdata[7:0];
            load_data = {{24{sign_ext & byte_v[7]}}, byte_v};
         end
         SZ_HALF: begin
            merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            load_data = {{16{sign_ext & half_v[15]}}, half_v};
            fault     = oob | lane[0];
         end
         SZ_WORD: begin
            merged = wdata;
            fault  = oob | (lane != 2'b00);
         end
         default: fault = 1'b1;
      endcase
   end

endmodule

// File: rtl/dm_ctrl.sv
// Word-organised data memory with byte/half/word access; commit LATENCY edges after acceptance,
// one-cycle ready pulse, req ignored while busy. Define DM_TRACE_EN to print each store commit.
module dm_ctrl
   import dm_pkg::*;
#(
   parameter int DEPTH   = 3072,
   parameter int ADDR_W  = 32,
   parameter int LATENCY = 1
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   input  logic [31:0]       pc,
   output logic              ready,
   output logic [31:0]       rdata,
   output logic              err
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   logic [31:0] mem [DEPTH];

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               accept, commit;

   logic               we_q, sext_q;
   logic [1:0]         size_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [31:0]        wdata_q, pc_q;

   logic [ADDR_W-3:0]  word_idx;
   logic [IDX_W-1:0]   mem_idx;
   logic               oob, fault;
   logic [31:0]        old_word, merged, load_data;

   // Everything below works from the captured address, never the live port.
   assign word_idx = addr_q[ADDR_W-1:2];
   assign mem_idx  = word_idx[IDX_W-1:0];
   assign oob      = word_idx >= (ADDR_W-2)'(DEPTH);
   assign old_word = oob ? '0 : mem[mem_idx];

   dm_lane_align u_align (
      .old_word  (old_word),
      .wdata     (wdata_q),
      .size      (size_q),
      .lane      (addr_q[1:0]),
      .sign_ext  (sext_q),
      .oob       (oob),
      .merged    (merged),
      .load_data (load_data),
      .fault     (fault)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               accept  = 1'b1;
               state_d = BUSY;
               cnt_d   = CNT_W'(LATENCY - 1);
            end
         end
         BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               commit  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ready   <= 1'b0;
         rdata   <= '0;
         err     <= 1'b0;
         we_q    <= 1'b0;
         sext_q  <= 1'b0;
         size_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         pc_q    <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready   <= commit;
         if (accept) begin
            we_q    <= we;
            sext_q  <= sign_ext;
            size_q  <= size;
            addr_q  <= addr;
            wdata_q <= wdata;
            pc_q    <= pc;
         end
         if (commit) begin
            rdata <= (fault || we_q) ? 32'h0 : load_data;
            err   <= fault;
            if (we_q && !fault) mem[mem_idx] <= merged;
         end
      end
   end

`ifdef DM_TRACE_EN
   always_ff @(posedge clk) begin
      if (!reset && commit && we_q && !fault)
         $display("@%h: *%h <= %h", pc_q, {word_idx, 2'b00}, merged);
   end
`else
   logic trace_unused;
   assign trace_unused = ^pc_q;
`endif

endmodule

// File: doc/dm_ctrl.md
# dm_ctrl

Parametrised data memory for the multi-cycle CPU datapath: word-organised storage with byte, halfword and word loads and stores. Loads use sign or zero extension. Every access uses a req/ready handshake with a configurable number of wait cycles, so the control FSM can stall on memory. The block replaces the single-cycle word-only data memory. It sits between the ALU address path and the register-file write-back mux.

## Interface
- `DEPTH`, 3072: number of 32-bit words stored.
- `ADDR_W`, 32: byte-address width.
- `LATENCY`, 1: wait cycles between acceptance and commit. Must be ≥1.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in 1: access request, sampled only in IDLE.
- `we` in 1: 1 = store, 0 = load.
- `size` in 2: access size. 00 = byte, 01 = half, 10 = word, 11 = reserved.
- `sign_ext` in 1: loads only. 1 = sign-extend, 0 = zero-extend.
- `addr` in ADDR_W: byte address.
- `wdata` in 32: store data, low-aligned (byte in [7:0], half in [15:0]).
- `pc` in 32: PC of the issuing instruction, used for the trace.
- `ready` out 1: one-cycle completion pulse.
- `rdata` out 32: load result, valid while `ready` = 1.
- `err` out 1: access faulted, valid while `ready` = 1.

## Operation
- Byte order is little-endian. Lane `addr[1:0]` = 0 is bits [7:0].
- Word index is `addr[ADDR_W-1:2]`.
- States:
  - IDLE: `req` = 1 captures `we`/`size`/`sign_ext`/`addr`/`wdata`/`pc`, loads `cnt` = LATENCY-1 and goes to BUSY.
  - BUSY: if `cnt` ≠ 0, decrement. If `cnt` = 0, commit, pulse `ready` and return to IDLE.
- Inputs that change after acceptance are ignored. `req` while BUSY is ignored (not queued).
- A fault is any of:
  - `size` = 11
  - half with `addr[0]` = 1
  - word with `addr[1:0]` ≠ 0
  - word index ≥ DEPTH
- A faulted access completes normally with `err` = 1 and `rdata` = 0. Memory is untouched.
- Store commit:
  - byte: replace the addressed lane with `wdata[7:0]`.
  - half: replace lanes {`addr[1]`,0}/+1 with `wdata[15:0]`.
  - word: replace the whole word.
  - Other lanes are preserved. `rdata` = 0.
- Load commit: extract the addressed byte or half, then extend per `sign_ext`. A word load is returned as-is.
- `rdata`/`err` hold their last completion values until the next completion or reset.

## Timing
- On reset: all DEPTH words = 0, state IDLE, `ready` = 0, `rdata` = 0, `err` = 0, `cnt` = 0.
- Reset mid-access aborts the access. No write is committed and no `ready` pulse is produced.
- Acceptance at edge k → commit at edge k+LATENCY → `ready` high for the cycle after that edge.
- The module is IDLE during the `ready` cycle. A `req` held high is accepted at that cycle's closing edge.
- Maximum throughput is one access per LATENCY+1 cycles.
- A load committed at edge k+LATENCY sees all stores committed at or before edge k+LATENCY-1.
- Memory is never read combinationally from live `addr`. Only the captured address is used.

## Configuration
- `DM_TRACE_EN` defined: at each non-faulted store commit edge, `$display("@%h: *%h <= %h", pc_q, {word_index,2'b00}, merged_word)`.
  - The address shown is the word-aligned byte address.
  - The data shown is the full 32-bit word after the merge.
- `DM_TRACE_EN` undefined: no display statements are compiled. Functional behaviour is identical.

## Structure
- Package `dm_pkg` holds:
  - the `size` encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD
  - the state enum IDLE/BUSY
- Sub-module `dm_lane_align` (combinational) holds:
  - store-side merge (old word, `wdata`, `size`, `addr[1:0]` → new word)
  - load-side extract/extend (word, `size`, `addr[1:0]`, `sign_ext` → `rdata`)
  - the fault decode
- The top level holds the FSM, `cnt`, capture registers, storage array and trace.

## Test plan
- Reset, then word load at 0x0 with LATENCY=1 → `ready` one cycle after the commit edge, `rdata` = 0x00000000, `err` = 0.
- Word store 0x11223344 @0x10, then sb 0xAA @0x12, then word load @0x10 → 0x11AA3344. The trace shows `*00000010 <= 11aa3344`.
- Word 0x0000F080 @0x20 gives:
  - lb @0x20 with `sign_ext` = 1 → 0xFFFFFF80
  - lbu @0x20 → 0x00000080
  - lh @0x20 with `sign_ext` = 1 → 0xFFFFF080
  - lhu @0x22 → 0x00000000
- sh @0x21 and sw @0x22 → `err` = 1, memory unchanged, no trace line. Word index DEPTH → `err` = 1.
- LATENCY=3, `req` held high continuously with `addr` changing mid-access → `ready` pulses every 4 cycles and each access uses its captured address.
- Reset asserted during BUSY of a store → no write occurs, no `ready`, and a subsequent load returns 0.
